// File: rtl/sobel_avmm_mem.sv
// sobel_avmm_mem
//   Avalon-MM responder memory for the sobel component's avmm_0_rw master.
//   Stores 64-bit words (source image and filtered output). Reads return
//   after a fixed READ_LATENCY and may stream one per cycle. Writes honour
//   byte enables. A second host port preloads images and reads back results.
//
// Parameters
//   WORDS         memory depth in 64-bit words
//   ADDR_W        word-index width, clog2(WORDS)
//   READ_LATENCY  cycles from accepted read to readdata update (1..4)
//   BASE_ADDR     byte base address of the window on avmm_0_rw_address
//
// Ports
//   clock, resetn          single rising-edge clock, synchronous active-low reset
//   avmm_0_rw_*            Avalon-MM slave: address, byteenable, read, readdata,
//                          write, writedata (no waitrequest)
//   host_addr/we/wdata     host word port, full-word writes
//   host_rdata             mem[host_addr] from the previous cycle
//   range_err              sticky, avmm access outside the window
//   proto_err              sticky, read and write in the same cycle
//   rd_count, wr_count     only with SOBEL_AVMM_MEM_STATS_EN defined: saturating
//                          counts of accepted in-range reads/writes
//
// Optional feature macro: SOBEL_AVMM_MEM_STATS_EN
module sobel_avmm_mem #(
  parameter int          WORDS        = 1024,
  parameter int          ADDR_W       = 10,
  parameter int          READ_LATENCY = 1,
  parameter logic [63:0] BASE_ADDR    = 64'd0
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [63:0]       avmm_0_rw_address,
  input  logic [7:0]        avmm_0_rw_byteenable,
  input  logic              avmm_0_rw_read,
  output logic [63:0]       avmm_0_rw_readdata,
  input  logic              avmm_0_rw_write,
  input  logic [63:0]       avmm_0_rw_writedata,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic              host_we,
  input  logic [63:0]       host_wdata,
  output logic [63:0]       host_rdata,
  output logic              range_err,
  output logic              proto_err
`ifdef SOBEL_AVMM_MEM_STATS_EN
  ,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
`endif
);

  localparam logic [63:0] LP_SPAN = 64'(WORDS) << 3;

  logic [63:0]       r_mem [WORDS];
  logic [63:0]       r_readdata;
  logic [63:0]       r_host_rdata;
  logic              r_range_err;
  logic              r_proto_err;

  logic [63:0]       w_off;
  logic              w_in_range;
  logic [ADDR_W-1:0] w_idx;
  logic              w_proto;
  logic              w_wr_en;
  logic              w_rd_ok;
  logic [63:0]       w_rd_word;
  logic              w_last_vld;
  logic [63:0]       w_last_data;

  // The >= test guards against the subtraction wrapping below BASE_ADDR.
  assign w_off      = avmm_0_rw_address - BASE_ADDR;
  assign w_in_range = (avmm_0_rw_address >= BASE_ADDR) && (w_off < LP_SPAN);
  assign w_idx      = w_off[ADDR_W+2:3];
  assign w_proto    = avmm_0_rw_read & avmm_0_rw_write;
  assign w_wr_en    = avmm_0_rw_write & w_in_range;
  assign w_rd_ok    = avmm_0_rw_read & w_in_range & ~avmm_0_rw_write;
  // Out-of-range and read+write collisions still return a word, forced to 0.
  assign w_rd_word  = w_rd_ok ? r_mem[w_idx] : 64'd0;

  // Memory is not reset. The avmm lane writes come after the host write so
  // they override it on enabled lanes when both hit the same word.
  always_ff @(posedge clock) begin
    if (host_we) begin
      r_mem[host_addr] <= host_wdata;
    end
    if (w_wr_en) begin
      for (int i = 0; i < 8; i++) begin
        if (avmm_0_rw_byteenable[i]) begin
          r_mem[w_idx][8*i +: 8] <= avmm_0_rw_writedata[8*i +: 8];
        end
      end
    end
  end

  // readdata is the final stage; READ_LATENCY-1 extra stages sit in front.
  generate
    if (READ_LATENCY <= 1) begin : g_lat1
      assign w_last_vld  = avmm_0_rw_read;
      assign w_last_data = w_rd_word;
    end else begin : g_latn
      logic        r_pipe_vld  [READ_LATENCY-1];
      logic [63:0] r_pipe_data [READ_LATENCY-1];

      always_ff @(posedge clock) begin
        if (!resetn) begin
          for (int i = 0; i < READ_LATENCY-1; i++) begin
            r_pipe_vld[i]  <= 1'b0;
            r_pipe_data[i] <= 64'd0;
          end
        end else begin
          r_pipe_vld[0]  <= avmm_0_rw_read;
          r_pipe_data[0] <= w_rd_word;
          for (int i = 1; i < READ_LATENCY-1; i++) begin
            r_pipe_vld[i]  <= r_pipe_vld[i-1];
            r_pipe_data[i] <= r_pipe_data[i-1];
          end
        end
      end

      assign w_last_vld  = r_pipe_vld[READ_LATENCY-2];
      assign w_last_data = r_pipe_data[READ_LATENCY-2];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_readdata   <= 64'd0;
      r_host_rdata <= 64'd0;
      r_range_err  <= 1'b0;
      r_proto_err  <= 1'b0;
    end else begin
      if (w_last_vld) begin
        r_readdata <= w_last_data;
      end
      r_host_rdata <= r_mem[host_addr];
      if ((avmm_0_rw_read | avmm_0_rw_write) && !w_in_range) begin
        r_range_err <= 1'b1;
      end
      if (w_proto) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign avmm_0_rw_readdata = r_readdata;
  assign host_rdata         = r_host_rdata;
  assign range_err          = r_range_err;
  assign proto_err          = r_proto_err;

`ifdef SOBEL_AVMM_MEM_STATS_EN
  logic [31:0] r_rd_count;
  logic [31:0] r_wr_count;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_rd_count <= 32'd0;
      r_wr_count <= 32'd0;
    end else begin
      if (w_rd_ok && (r_rd_count != 32'hFFFF_FFFF)) begin
        r_rd_count <= r_rd_count + 32'd1;
      end
      if (w_wr_en && (r_wr_count != 32'hFFFF_FFFF)) begin
        r_wr_count <= r_wr_count + 32'd1;
      end
    end
  end

  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;
`endif

endmodule
